// File: rtl/axi_read_only_ctrl.sv
// AXI4 read-channel slave: turns INCR AR bursts into single-port SRAM reads through an
// arbitrated request port and returns the words on R via a 2-entry tagged FIFO.
module axi_read_only_ctrl #(
    parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI4_RDATA_WIDTH   = 64,
    parameter int unsigned AXI4_ID_WIDTH      = 16,
    parameter int unsigned AXI4_USER_WIDTH    = 10,
    parameter int unsigned AXI_NUMBYTES       = AXI4_RDATA_WIDTH / 8,
    parameter int unsigned MEM_ADDR_WIDTH     = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
    input  logic [7:0]                    ARLEN_i,
    input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
    input  logic                          ARVALID_i,
    output logic                          ARREADY_o,
    output logic [AXI4_ID_WIDTH-1:0]      RID_o,
    output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
    output logic [1:0]                    RRESP_o,
    output logic                          RLAST_o,
    output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
    output logic                          RVALID_o,
    input  logic                          RREADY_i,
    output logic                          MEM_CEN_o,
    output logic                          MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
    output logic [AXI4_RDATA_WIDTH-1:0]   MEM_D_o,
    output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
    input  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i,
    input  logic                          grant_i,
    output logic                          valid_o
);

    localparam int unsigned OFFSET_BIT = $clog2(AXI4_RDATA_WIDTH) - 3;
    localparam int unsigned TAG_W      = AXI4_ID_WIDTH + AXI4_USER_WIDTH + 1;

    typedef enum logic {StIdle = 1'b0, StBurst = 1'b1} state_e;

    state_e                        state_q, state_d;
    logic [AXI4_ID_WIDTH-1:0]      id_q;
    logic [AXI4_USER_WIDTH-1:0]    user_q;
    logic [7:0]                    len_q;
    logic [MEM_ADDR_WIDTH-1:0]     base_q;
    logic [8:0]                    count_q;
    logic                          inflight_q;
    logic [TAG_W-1:0]              tag_q;
    logic [AXI4_RDATA_WIDTH-1:0]   fifo_data_q [2];
    logic [TAG_W-1:0]              fifo_tag_q  [2];
    logic                          rd_ptr_q, wr_ptr_q;
    logic [1:0]                    fifo_cnt_q, fifo_cnt_d;

    logic ar_hs, pop, issue_ok, issue, last;
    logic unused_addr;

    assign unused_addr = ^{ARADDR_i[AXI4_ADDRESS_WIDTH-1:MEM_ADDR_WIDTH+OFFSET_BIT],
                           ARADDR_i[OFFSET_BIT-1:0]};

    assign ar_hs = (state_q == StIdle) & ARVALID_i;
    assign pop   = RVALID_o & RREADY_i;
    assign last  = (count_q == {1'b0, len_q});
    // Credits: buffered beats plus the one in flight may never exceed the FIFO depth.
    assign issue_ok = (state_q == StBurst) &
                      ((({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd2) | pop);
    assign issue = issue_ok & grant_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ARVALID_i) state_d = StBurst;
            StBurst: if (issue && last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({inflight_q, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    assign ARREADY_o = (state_q == StIdle);
    assign valid_o   = issue_ok;
    assign MEM_CEN_o = ~issue;
    assign MEM_WEN_o = 1'b1;
    assign MEM_A_o   = base_q + MEM_ADDR_WIDTH'(count_q);
    assign MEM_D_o   = '0;
    assign MEM_BE_o  = '1;

    assign RVALID_o = (fifo_cnt_q != 2'd0);
    assign RDATA_o  = fifo_data_q[rd_ptr_q];
    assign RID_o    = fifo_tag_q[rd_ptr_q][TAG_W-1 -: AXI4_ID_WIDTH];
    assign RUSER_o  = fifo_tag_q[rd_ptr_q][AXI4_USER_WIDTH:1];
    assign RLAST_o  = fifo_tag_q[rd_ptr_q][0];
    assign RRESP_o  = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            id_q           <= '0;
            user_q         <= '0;
            len_q          <= '0;
            base_q         <= '0;
            count_q        <= '0;
            inflight_q     <= 1'b0;
            tag_q          <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_tag_q[0]  <= '0;
            fifo_tag_q[1]  <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            fifo_cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (ar_hs) begin
                id_q    <= ARID_i;
                user_q  <= ARUSER_i;
                len_q   <= ARLEN_i;
                base_q  <= ARADDR_i[MEM_ADDR_WIDTH+OFFSET_BIT-1:OFFSET_BIT];
                count_q <= '0;
            end else if (issue) begin
                count_q <= count_q + 9'd1;
            end
            inflight_q <= issue;
            if (issue) tag_q <= {id_q, user_q, last};
            // Memory data arrives the cycle after a granted request.
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= MEM_Q_i;
                fifo_tag_q[wr_ptr_q]  <= tag_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_read_only_ctrl.sv
// Self-checking bench for axi_read_only_ctrl: burst-level reference model of expected
// memory addresses and R beats, with scenario tasks and randomized grant/ready traffic.
module tb_axi_read_only_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ARID_i;
    logic [31:0] ARADDR_i;
    logic [7:0]  ARLEN_i;
    logic [9:0]  ARUSER_i;
    logic        ARVALID_i;
    logic        ARREADY_o;
    logic [15:0] RID_o;
    logic [63:0] RDATA_o;
    logic [1:0]  RRESP_o;
    logic        RLAST_o;
    logic [9:0]  RUSER_o;
    logic        RVALID_o;
    logic        RREADY_i;
    logic        MEM_CEN_o;
    logic        MEM_WEN_o;
    logic [12:0] MEM_A_o;
    logic [63:0] MEM_D_o;
    logic [7:0]  MEM_BE_o;
    logic [63:0] MEM_Q_i;
    logic        grant_i;
    logic        valid_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] id;
        logic [9:0]  user;
        logic        last;
        logic [63:0] data;
    } beat_t;

    beat_t       exp_r[$];
    logic [12:0] exp_a[$];

    axi_read_only_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARUSER_i(ARUSER_i),
        .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
        .RID_o(RID_o), .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RLAST_o(RLAST_o),
        .RUSER_o(RUSER_o), .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
        .MEM_CEN_o(MEM_CEN_o), .MEM_WEN_o(MEM_WEN_o), .MEM_A_o(MEM_A_o), .MEM_D_o(MEM_D_o),
        .MEM_BE_o(MEM_BE_o), .MEM_Q_i(MEM_Q_i), .grant_i(grant_i), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] data_of(input logic [12:0] a);
        return {16'hC0DE, 3'b000, a, ~{19'b0, a} ^ 32'h1234_5678};
    endfunction

    // SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (!MEM_CEN_o) MEM_Q_i <= data_of(MEM_A_o);
    end

    // Scoreboard: address order, beat contents, and R stability while stalled.
    logic        prev_stall = 1'b0;
    logic [90:0] prev_r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                checks++;
                if ({RVALID_o, RID_o, RUSER_o, RLAST_o, RDATA_o} !== {1'b1, prev_r}) begin
                    errors++;
                    $display("FAIL stall_stable got %h exp %h",
                             {RVALID_o, RID_o, RUSER_o, RLAST_o, RDATA_o}, {1'b1, prev_r});
                end
            end
            prev_stall = RVALID_o & !RREADY_i;
            prev_r     = {RID_o, RUSER_o, RLAST_o, RDATA_o};
            if (!MEM_CEN_o) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL mem_addr got %h exp none", MEM_A_o);
                end else begin
                    logic [12:0] ea;
                    ea = exp_a.pop_front();
                    if (MEM_A_o !== ea || valid_o !== 1'b1) begin
                        errors++;
                        $display("FAIL mem_addr got %h/v%b exp %h/v1", MEM_A_o, valid_o, ea);
                    end
                end
            end
            if (RVALID_o && RREADY_i) begin
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL r_beat got id %h last %b exp none", RID_o, RLAST_o);
                end else begin
                    beat_t eb;
                    eb = exp_r.pop_front();
                    if ({RID_o, RUSER_o, RLAST_o, RDATA_o, RRESP_o} !== {eb, 2'b00}) begin
                        errors++;
                        $display("FAIL r_beat got %h %h %b %h %b exp %h %h %b %h 00",
                                 RID_o, RUSER_o, RLAST_o, RDATA_o, RRESP_o,
                                 eb.id, eb.user, eb.last, eb.data);
                    end
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_ar(input logic [15:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [9:0] user);
        int n = 0;
        logic [12:0] base;
        ARID_i = id; ARADDR_i = addr; ARLEN_i = len; ARUSER_i = user; ARVALID_i = 1'b1;
        forever begin
            @(negedge clk);
            if (ARREADY_o === 1'b1) break;
            n++;
            if (n > 3000) break;
        end
        checks++;
        if (n > 3000) begin
            errors++;
            $display("FAIL ar_accept got timeout exp ARREADY within 3000 cycles");
        end else begin
            base = addr[15:3];
            for (int i = 0; i <= int'(len); i++) begin
                exp_a.push_back(13'(base + 13'(i)));
                exp_r.push_back('{id, user, (i == int'(len)), data_of(13'(base + 13'(i)))});
            end
        end
        @(posedge clk);
        #1 ARVALID_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_r.size() != 0 || exp_a.size() != 0 || RVALID_o !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > 5000) break;
        end
        checks++;
        if (n > 5000) begin
            errors++;
            $display("FAIL drain got %0d beats %0d addrs left exp 0", exp_r.size(), exp_a.size());
            exp_r.delete();
            exp_a.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ARVALID_i = 1'b0; ARID_i = '0; ARADDR_i = '0; ARLEN_i = '0;
        ARUSER_i = '0; RREADY_i = 1'b0; grant_i = 1'b0; MEM_Q_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ARREADY_o, RVALID_o, MEM_CEN_o, valid_o, RLAST_o} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 10100",
                     {ARREADY_o, RVALID_o, MEM_CEN_o, valid_o, RLAST_o});
        end
        checks++;
        if ({RID_o, RUSER_o, RDATA_o, RRESP_o} !== '0) begin
            errors++;
            $display("FAIL reset_r got %h %h %h %b exp 0", RID_o, RUSER_o, RDATA_o, RRESP_o);
        end
        checks++;
        if ({MEM_WEN_o, MEM_BE_o, MEM_D_o} !== {1'b1, 8'hFF, 64'h0}) begin
            errors++;
            $display("FAIL reset_mem got %b %h %h exp 1 ff 0", MEM_WEN_o, MEM_BE_o, MEM_D_o);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        grant_i = 1'b1; RREADY_i = 1'b1;
        send_ar(16'd5, 32'h40, 8'd0, 10'h2A);
        @(negedge clk);
        checks++;
        if ({valid_o, MEM_CEN_o, MEM_A_o} !== {1'b1, 1'b0, 13'd8}) begin
            errors++;
            $display("FAIL single_req got v%b cen%b a%h exp v1 cen0 a0008",
                     valid_o, MEM_CEN_o, MEM_A_o);
        end
        @(negedge clk);
        checks++;
        if (RVALID_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early_rvalid got %b exp 0", RVALID_o);
        end
        @(negedge clk);
        checks++;
        if ({RVALID_o, RID_o, RLAST_o} !== {1'b1, 16'd5, 1'b1}) begin
            errors++;
            $display("FAIL single_latency got v%b id%h l%b exp v1 id0005 l1",
                     RVALID_o, RID_o, RLAST_o);
        end
        wait_drain();
    endtask

    task automatic test_burst();
        int n = 0;
        grant_i = 1'b1; RREADY_i = 1'b1;
        send_ar(16'h1234, 32'h80, 8'd3, 10'h155);
        while (RVALID_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({RVALID_o, RLAST_o} !== {1'b1, (i == 3)}) begin
                errors++;
                $display("FAIL burst_beat%0d got v%b l%b exp v1 l%b", i, RVALID_o, RLAST_o,
                         (i == 3));
            end
            @(negedge clk);
        end
        checks++;
        if (RVALID_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_extra got %b exp 0", RVALID_o);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        grant_i = 1'b1; RREADY_i = 1'b0;
        send_ar(16'h0BEE, 32'h1000, 8'd7, 10'h001);
        repeat (8) @(negedge clk);
        checks++;
        if ({valid_o, MEM_CEN_o, RVALID_o} !== 3'b011) begin
            errors++;
            $display("FAIL bp_hold got v%b cen%b rv%b exp v0 cen1 rv1",
                     valid_o, MEM_CEN_o, RVALID_o);
        end
        checks++;
        if (exp_a.size() != 6) begin
            errors++;
            $display("FAIL bp_issued got %0d pending exp 6", exp_a.size());
        end
        @(posedge clk);
        #1 RREADY_i = 1'b1;
        wait_drain();
    endtask

    task automatic test_grant_stall();
        grant_i = 1'b1; RREADY_i = 1'b1;
        send_ar(16'h00A1, 32'h2000, 8'd5, 10'h3FF);
        repeat (2) @(posedge clk);
        #1 grant_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({valid_o, MEM_CEN_o, MEM_A_o} !== {1'b1, 1'b1, 13'h402}) begin
                errors++;
                $display("FAIL gstall%0d got v%b cen%b a%h exp v1 cen1 a0402",
                         i, valid_o, MEM_CEN_o, MEM_A_o);
            end
        end
        @(posedge clk);
        #1 grant_i = 1'b1;
        wait_drain();
    endtask

    task automatic test_wrap_overlap();
        grant_i = 1'b1; RREADY_i = 1'b1;
        send_ar(16'd7, 32'h0000_FFF0, 8'd3, 10'h011);
        send_ar(16'd9, $urandom, 8'd2, 10'h022);
        @(negedge clk);
        checks++;
        if ({RVALID_o, RID_o, RLAST_o} !== {1'b1, 16'd7, 1'b1}) begin
            errors++;
            $display("FAIL overlap_drain got v%b id%h l%b exp v1 id0007 l1",
                     RVALID_o, RID_o, RLAST_o);
        end
        wait_drain();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                send_ar(16'($urandom), $urandom, 8'd255, 10'($urandom));
                for (int k = 0; k < 12; k++)
                    send_ar(16'($urandom), $urandom, 8'($urandom_range(0, 15)), 10'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    grant_i  = ($urandom_range(0, 3) != 0);
                    RREADY_i = ($urandom_range(0, 2) != 0);
                end
            end
        join
        grant_i = 1'b1; RREADY_i = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        int n  = 0;
        grant_i = 1'b1; RREADY_i = 1'b1;
        send_ar(16'h0D0D, 32'h3000, 8'd7, 10'h0AA);
        while (hs < 2 && n < 50) begin
            @(negedge clk);
            if (RVALID_o && RREADY_i) hs++;
            n++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_r.delete();
        exp_a.delete();
        #1;
        checks++;
        if ({RVALID_o, MEM_CEN_o, valid_o, ARREADY_o, RLAST_o} !== 5'b01010) begin
            errors++;
            $display("FAIL reset_mid got %b exp 01010",
                     {RVALID_o, MEM_CEN_o, valid_o, ARREADY_o, RLAST_o});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ARREADY_o, RVALID_o} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got %b exp 10", {ARREADY_o, RVALID_o});
        end
        @(posedge clk);
        #1;
        send_ar(16'h0E0E, 32'h4440, 8'd4, 10'h0BB);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_grant_stall();
        test_wrap_overlap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
